// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants for the sram-like arbiter: source ids and grant FSM encodings.
package sram_like_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_order_fifo.sv
// 1-bit-wide order FIFO recording which master owns each accepted transaction.
module arb_order_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is read combinationally so data_ok routing stays zero-latency.
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter with grant locking and in-order response routing.
// Define ARB_RR_EN for round-robin arbitration; default is data-over-inst priority.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = $clog2(OUTSTANDING) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy
);

  arb_state_t       state_reg;
  arb_state_t       state_next;
  logic             winner;
  logic             winner_req;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;

`ifdef ARB_RR_EN
  logic last_winner_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner_reg <= SRC_INST;
    end else if (accept) begin
      last_winner_reg <= winner;
    end
  end
`endif

  always_comb begin
    winner = SRC_INST;
    case (state_reg)
      ARB_HOLD_I: winner = SRC_INST;
      ARB_HOLD_D: winner = SRC_DATA;
      default: begin
`ifdef ARB_RR_EN
        if (inst_sram_req && data_sram_req) begin
          winner = ~last_winner_reg;
        end else if (data_sram_req) begin
          winner = SRC_DATA;
        end
`else
        if (data_sram_req) begin
          winner = SRC_DATA;
        end
`endif
      end
    endcase
  end

  assign winner_req = (winner == SRC_DATA) ? data_sram_req : inst_sram_req;
  assign mem_req    = winner_req & ~fifo_full;
  assign accept     = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = inst_sram_wr;
    mem_size  = inst_sram_size;
    mem_wstrb = inst_sram_wstrb;
    mem_addr  = inst_sram_addr;
    mem_wdata = inst_sram_wdata;
    if (winner == SRC_DATA) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_next = (winner == SRC_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
        end
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        // A held master dropping req is tolerated: release the lock.
        if (!winner_req || accept) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign inst_sram_addr_ok = accept & (winner == SRC_INST);
  assign data_sram_addr_ok = accept & (winner == SRC_DATA);

  assign pop               = mem_data_ok & ~fifo_empty;
  assign inst_sram_data_ok = pop & (fifo_head == SRC_INST);
  assign data_sram_data_ok = pop & (fifo_head == SRC_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;
  assign arb_busy          = ~fifo_empty;

  arb_order_fifo #(
    .DEPTH (OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (winner),
    .pop   (mem_data_ok),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_sram_like_arbiter;

  localparam int OUTSTANDING = 4;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, arb_busy;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;

  int pass_cnt  = 0;
  int check_cnt = 0;

  sram_like_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_req),
    .inst_sram_wr      (inst_wr),
    .inst_sram_size    (inst_size),
    .inst_sram_wstrb   (inst_wstrb),
    .inst_sram_addr    (inst_addr),
    .inst_sram_wdata   (inst_wdata),
    .inst_sram_addr_ok (inst_addr_ok),
    .inst_sram_data_ok (inst_data_ok),
    .inst_sram_rdata   (inst_rdata),
    .data_sram_req     (data_req),
    .data_sram_wr      (data_wr),
    .data_sram_size    (data_size),
    .data_sram_wstrb   (data_wstrb),
    .data_sram_addr    (data_addr),
    .data_sram_wdata   (data_wdata),
    .data_sram_addr_ok (data_addr_ok),
    .data_sram_data_ok (data_data_ok),
    .data_sram_rdata   (data_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata),
    .arb_busy          (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    mem_data_ok = 1;
    #2;
    check_cnt++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arb_busy} !== 6'b0)
      $display("FAIL reset_outputs: got %b required 000000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arb_busy});
    else pass_cnt++;
    step();
    reset = 0;
    mem_data_ok = 0;
    $display("txn reset released");
  endtask

  task automatic test_inst_load();
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    check_cnt++;
    if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b110 || mem_addr !== 32'h1C00_0000)
      $display("FAIL inst_load_accept: req/iok/dok=%b addr=%h required 110 1c000000",
               {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
    else pass_cnt++;
    step();
    inst_req = 0; mem_addr_ok = 0;
    step();
    mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    #1;
    check_cnt++;
    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0280_0C0C)
      $display("FAIL inst_load_resp: iok=%b dok=%b rdata=%h required 1 0 02800c0c",
               inst_data_ok, data_data_ok, inst_rdata);
    else pass_cnt++;
    step();
    mem_data_ok = 0;
    #1;
    check_cnt++;
    if (arb_busy !== 1'b0) $display("FAIL inst_load_busy: got %b required 0", arb_busy);
    else pass_cnt++;
    $display("txn inst load 1c000000 -> 02800c0c");
  endtask

  task automatic test_both_fixed();
    inst_req = 1; inst_addr = 32'h1C00_0100;
    data_req = 1; data_addr = 32'h8000_0200;
    mem_addr_ok = 1;
    #1;
    check_cnt++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || mem_addr !== 32'h8000_0200)
      $display("FAIL both_first: dok=%b iok=%b addr=%h required 1 0 80000200",
               data_addr_ok, inst_addr_ok, mem_addr);
    else pass_cnt++;
    step();
    data_req = 0;
    #1;
    check_cnt++;
    if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1C00_0100)
      $display("FAIL both_second: iok=%b addr=%h required 1 1c000100", inst_addr_ok, mem_addr);
    else pass_cnt++;
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check_cnt++;
    if ({data_data_ok, inst_data_ok} !== 2'b10)
      $display("FAIL both_resp1: d/i data_ok=%b required 10", {data_data_ok, inst_data_ok});
    else pass_cnt++;
    step();
    check_cnt++;
    if ({data_data_ok, inst_data_ok} !== 2'b01)
      $display("FAIL both_resp2: d/i data_ok=%b required 01", {data_data_ok, inst_data_ok});
    else pass_cnt++;
    step();
    mem_data_ok = 0;
    $display("txn both masters: data then inst");
  endtask

  // first_data=1: data is stalled and inst raises req; otherwise the reverse.
  task automatic test_stall(input bit first_data);
    logic [31:0] a_first;
    logic [31:0] a_second;
    a_first  = first_data ? 32'h8000_0300 : 32'h1C00_0300;
    a_second = first_data ? 32'h1C00_0400 : 32'h8000_0400;
    inst_addr = first_data ? a_second : a_first;
    data_addr = first_data ? a_first : a_second;
    if (first_data) data_req = 1; else inst_req = 1;
    mem_addr_ok = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        if (first_data) inst_req = 1; else data_req = 1;
      end
      if (c == 3) mem_addr_ok = 1;
      #1;
      check_cnt++;
      if (mem_addr !== a_first || mem_req !== 1'b1 ||
          (first_data ? inst_addr_ok : data_addr_ok) !== 1'b0 ||
          (first_data ? data_addr_ok : inst_addr_ok) !== (c == 3))
        $display("FAIL stall_hold_c%0d: addr=%h req=%b iok=%b dok=%b required addr %h",
                 c, mem_addr, mem_req, inst_addr_ok, data_addr_ok, a_first);
      else pass_cnt++;
      step();
    end
    if (first_data) data_req = 0; else inst_req = 0;
    #1;
    check_cnt++;
    if (mem_addr !== a_second || (first_data ? inst_addr_ok : data_addr_ok) !== 1'b1)
      $display("FAIL stall_second: addr=%h iok=%b dok=%b required addr %h",
               mem_addr, inst_addr_ok, data_addr_ok, a_second);
    else pass_cnt++;
    step();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_cnt++;
      if ((k == 0 ? {data_data_ok, inst_data_ok} : {inst_data_ok, data_data_ok})
          !== (first_data ? 2'b10 : 2'b01))
        $display("FAIL stall_resp%0d: d/i data_ok=%b%b", k, data_data_ok, inst_data_ok);
      else pass_cnt++;
      step();
    end
    mem_data_ok = 0;
    $display("txn stall first_data=%0d", first_data);
  endtask

  task automatic test_full();
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < OUTSTANDING; k++) begin
      inst_addr = 32'h1C00_1000 + 32'(k * 4);
      step();
    end
    #1;
    check_cnt++;
    if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0)
      $display("FAIL full_block: req=%b iok=%b required 0 0", mem_req, inst_addr_ok);
    else pass_cnt++;
    step();
    mem_data_ok = 1;
    #1;
    check_cnt++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b1)
      $display("FAIL full_nobypass: req=%b idok=%b required 0 1", mem_req, inst_data_ok);
    else pass_cnt++;
    step();
    mem_data_ok = 0;
    #1;
    check_cnt++;
    if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1)
      $display("FAIL full_reissue: req=%b iok=%b required 1 1", mem_req, inst_addr_ok);
    else pass_cnt++;
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    repeat (OUTSTANDING) step();
    mem_data_ok = 0;
    #1;
    check_cnt++;
    if (arb_busy !== 1'b0) $display("FAIL full_drain: busy=%b required 0", arb_busy);
    else pass_cnt++;
    $display("txn full fifo: %0d accepts, blocked, reissue", OUTSTANDING + 1);
  endtask

  task automatic test_store();
    logic [31:0] wd;
    wd = $urandom;
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_wdata = wd;
    data_addr = 32'h8000_0500; mem_addr_ok = 1;
    #1;
    check_cnt++;
    if (mem_wr !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== wd || data_addr_ok !== 1'b1)
      $display("FAIL store_issue: wr=%b wstrb=%b wdata=%h aok=%b required 1 0011 %h 1",
               mem_wr, mem_wstrb, mem_wdata, data_addr_ok, wd);
    else pass_cnt++;
    step();
    data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check_cnt++;
    if ({data_data_ok, inst_data_ok} !== 2'b10)
      $display("FAIL store_resp: d/i data_ok=%b required 10", {data_data_ok, inst_data_ok});
    else pass_cnt++;
    step();
    mem_data_ok = 0;
    $display("txn store wdata=%h", wd);
  endtask

  task automatic test_reset_mid();
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h1C00_2000; data_addr = 32'h8000_2000;
    step();
    data_req = 0;
    step();
    inst_req = 0; mem_addr_ok = 0;
    #3;
    reset = 1;
    #1;
    reset = 0;
    #1;
    check_cnt++;
    if (arb_busy !== 1'b0) $display("FAIL rstmid_busy: got %b required 0", arb_busy);
    else pass_cnt++;
    step();
    mem_data_ok = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_cnt++;
      if ({inst_data_ok, data_data_ok, arb_busy} !== 3'b000)
        $display("FAIL rstmid_late%0d: i/d data_ok busy=%b required 000",
                 k, {inst_data_ok, data_data_ok, arb_busy});
      else pass_cnt++;
      step();
    end
    mem_data_ok = 0;
    $display("txn reset mid-transaction");
  endtask

  // Model: outstanding owners in a queue; a stalled issue locks the grant to its master.
  task automatic test_random();
    bit q[$];
    int lock_src = -1;
    bit last_src = 1'b0;
    bit w, wreq, exp_req, acc, exp_idok, exp_ddok;
    int txn = 0;
    for (int c = 0; c < 400; c++) begin
      inst_req = ($urandom_range(0, 3) != 0);
      data_req = ($urandom_range(0, 2) == 0);
      inst_addr = $urandom; data_addr = $urandom;
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      if (lock_src >= 0) w = lock_src[0];
`ifdef ARB_RR_EN
      else if (inst_req && data_req) w = ~last_src;
`endif
      else w = data_req;
      wreq     = w ? data_req : inst_req;
      exp_req  = wreq && (q.size() < OUTSTANDING);
      acc      = exp_req && mem_addr_ok;
      exp_idok = mem_data_ok && q.size() > 0 && q[0] == 1'b0;
      exp_ddok = mem_data_ok && q.size() > 0 && q[0] == 1'b1;
      #1;
      check_cnt++;
      if (mem_req !== exp_req || mem_addr !== (w ? data_addr : inst_addr) ||
          inst_addr_ok !== (acc && !w) || data_addr_ok !== (acc && w) ||
          inst_data_ok !== exp_idok || data_data_ok !== exp_ddok ||
          arb_busy !== (q.size() != 0) || data_rdata !== mem_rdata)
        $display("FAIL random_c%0d: req=%b addr=%h aok=%b%b dok=%b%b busy=%b required req=%b addr=%h aok=%b%b dok=%b%b busy=%b",
                 c, mem_req, mem_addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                 arb_busy, exp_req, (w ? data_addr : inst_addr), acc && !w, acc && w,
                 exp_idok, exp_ddok, (q.size() != 0));
      else pass_cnt++;
      if (mem_data_ok && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(w);
        last_src = w;
        txn++;
        $display("txn random %0d: src=%0d addr=%h", txn, w, w ? data_addr : inst_addr);
      end
      if (lock_src >= 0) begin
        if (!wreq || acc) lock_src = -1;
      end else if (exp_req && !mem_addr_ok) begin
        lock_src = int'(w);
      end
      step();
    end
    idle_inputs();
    mem_data_ok = 1;
    repeat (OUTSTANDING + 1) step();
    mem_data_ok = 0;
  endtask

  initial begin
    test_reset();
    test_inst_load();
    test_both_fixed();
    test_stall(1'b1);
    test_stall(1'b0);
    test_full();
    test_store();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
